da_shift_accumulator: RTL and testbench

- Downstream consumer of the per-tap right-shift registers in the distributed-arithmetic (DA) FIR datapath.
- Sequences those registers with load and enable, and takes one serial bit per tap per cycle, LSB first.
- Forms the DA LUT partial sum for each bit-slice and shift-accumulates it into the exact signed dot product y = sum(coef_k * x_k).
- Sign bit-slice is subtracted, so samples and coefficients are two's complement.

---
 rtl/da_pkg.sv | 33 +++
 rtl/da_lut.sv | 32 +++
 rtl/da_shift_accumulator.sv | 103 ++++++++++
 tb/tb_da_shift_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : da_pkg                                                        |
// | Brief    : Shared state encoding and width helpers for the DA datapath.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package da_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Exact width of a K-tap signed dot product of N-bit samples and CW-bit coefficients.
    function automatic int da_aw(input int n, input int k, input int cw);
        return cw + clog2(k) + n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/da_lut.sv
// +--------------------------------------------------------------------------+
// | Module   : da_lut                                                        |
// | Brief    : Combinational DA partial sum of coefficients selected by bits.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module da_lut
    import da_pkg::*;
#(
    parameter int K  = 4,
    parameter int CW = 16,
    parameter int AW = CW + clog2(K)
) (
    input  logic [K*CW-1:0] i_coef,
    input  logic [K-1:0]    i_x_bits,
    output logic [AW-1:0]   o_p
);

    always_comb begin
        o_p = '0;
        for (int k = 0; k < K; k++) begin
            if (i_x_bits[k]) begin
                o_p = o_p + {{(AW-CW){i_coef[k*CW+CW-1]}}, i_coef[k*CW +: CW]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/da_shift_accumulator.sv
// +--------------------------------------------------------------------------+
// | Module   : da_shift_accumulator                                          |
// | Brief    : Sequences tap shift registers and bit-serially accumulates    |
// |            the signed DA dot product, sign slice subtracted.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module da_shift_accumulator
    import da_pkg::*;
#(
    parameter int N  = 20,
    parameter int K  = 4,
    parameter int CW = 16,
    parameter int AW = da_aw(N, K, CW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [K*CW-1:0] coef,
    input  logic [K-1:0]    x_bits,
    output logic            load,
    output logic            enable,
    output logic            busy,
    output logic [AW-1:0]   y,
    output logic            y_valid
);

    localparam int                 c_CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    logic [1:0]         r_state;
    logic [K*CW-1:0]    r_coef;
    logic [c_CNT_W-1:0] r_cnt;
    logic [AW-1:0]      r_acc;
    logic [AW-1:0]      r_y;
    logic               r_y_valid;
    logic [AW-1:0]      w_p;
    logic [AW-1:0]      w_p_shift;

    da_lut #(
        .K  (K),
        .CW (CW),
        .AW (AW)
    ) u_lut (
        .i_coef   (r_coef),
        .i_x_bits (x_bits),
        .o_p      (w_p)
    );

    // Weight the slice by 2^j; two's-complement left shift preserves sign at AW bits.
    assign w_p_shift = w_p << r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_coef    <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_coef  <= coef;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_state <= c_SHIFT;
                end
                c_SHIFT: begin
                    // The MSB slice carries negative weight in two's complement.
                    if (r_cnt == c_LAST) begin
                        r_y       <= r_acc - w_p_shift;
                        r_y_valid <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_acc <= r_acc + w_p_shift;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign load    = (r_state == c_LOAD);
    assign enable  = (r_state == c_SHIFT);
    assign busy    = (r_state != c_IDLE);
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule

`default_nettype wire

// File: tb/tb_da_shift_accumulator.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_da_shift_accumulator                                       |
// | Brief    : Directed bench for da_shift_accumulator with tap shift regs.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_da_shift_accumulator;

    localparam int N  = 8;
    localparam int K  = 4;
    localparam int CW = 8;
    localparam int AW = 18;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [K*CW-1:0] coef;
    logic [K-1:0]    x_bits;
    logic            load;
    logic            enable;
    logic            busy;
    logic [AW-1:0]   y;
    logic            y_valid;

    logic [N-1:0] samp [K];
    logic [N-1:0] sr   [K] = '{default: '0};

    int vectors    = 0;
    int miscompares = 0;

    da_shift_accumulator #(
        .N  (N),
        .K  (K),
        .CW (CW),
        .AW (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .coef    (coef),
        .x_bits  (x_bits),
        .load    (load),
        .enable  (enable),
        .busy    (busy),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    // Right-shift tap registers feeding LSB first.
    always @(posedge clk) begin
        for (int k = 0; k < K; k++) begin
            if (load) begin
                sr[k] <= samp[k];
            end else if (enable) begin
                sr[k] <= sr[k] >> 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < K; k++) begin
            x_bits[k] = sr[k][0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
        coef = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endtask

    task automatic set_samp(input int s0, input int s1, input int s2, input int s3);
        samp[0] = N'(s0);
        samp[1] = N'(s1);
        samp[2] = N'(s2);
        samp[3] = N'(s3);
    endtask

    // Full single run: start sampled at edge t, result checked in cycle t+10.
    task automatic run(input string tag, input int exp_y);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_load"}, 32'(load), 1);
        check({tag, "_en_in_load"}, 32'(enable), 0);
        check({tag, "_busy"}, 32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            tick();
            check({tag, "_enable"}, 32'(enable), 1);
        end
        tick();
        check({tag, "_y_valid"}, 32'(y_valid), 1);
        check({tag, "_y"}, $signed(y), exp_y);
        check({tag, "_idle"}, 32'(busy), 0);
        tick();
        check({tag, "_y_valid_drop"}, 32'(y_valid), 0);
        check({tag, "_y_hold"}, $signed(y), exp_y);
    endtask

    initial begin
        int exp_b2b [3];
        reset = 1'b1;
        start = 1'b0;
        set_coef(0, 0, 0, 0);
        set_samp(0, 0, 0, 0);
        repeat (3) tick();
        check("rst_load", 32'(load), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_y", $signed(y), 0);
        check("rst_y_valid", 32'(y_valid), 0);
        reset = 1'b0;
        tick();

        set_coef(1, 2, 3, 4);       set_samp(1, 1, 1, 1);           run("basic", 10);
        set_coef(5, 0, 0, 0);       set_samp(-1, 0, 0, 0);          run("neg_x", -5);
        set_coef(127, 0, 0, 0);     set_samp(-128, 0, 0, 0);        run("min_x", -16256);
        set_coef(-128, -128, -128, -128); set_samp(-128, -128, -128, -128); run("all_min", 65536);
        set_coef(127, 127, 127, 127); set_samp(127, -128, 127, -128); run("mixed_ext", -254);

        // Start pulses during the run must be ignored.
        set_coef(1, 2, 3, 4);
        set_samp(10, 20, -30, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            start = (c == 3 || c == 7);
            tick();
            if (c < 10) check("busy_ign_no_valid", 32'(y_valid), 0);
        end
        start = 1'b0;
        check("busy_ign_valid", 32'(y_valid), 1);
        check("busy_ign_y", $signed(y), -20);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("busy_ign_single", 32'(y_valid), 0);
        end
        check("busy_ign_idle", 32'(busy), 0);

        // Back-to-back with start held; samples change after each load.
        exp_b2b = '{10, -10, 100};
        set_coef(1, 2, 3, 4);
        set_samp(1, 1, 1, 1);
        start = 1'b1;
        tick();
        for (int c = 2; c <= 31; c++) begin
            tick();
            if (c == 2)  set_samp(-1, -1, -1, -1);
            if (c == 12) set_samp(100, 0, 0, 0);
            if (c % 10 == 0) begin
                check("b2b_valid", 32'(y_valid), 1);
                check("b2b_y", $signed(y), exp_b2b[c/10 - 1]);
            end else begin
                check("b2b_no_valid", 32'(y_valid), 0);
            end
            if (c == 30) start = 1'b0;
        end
        check("b2b_idle", 32'(busy), 0);

        // Reset in SHIFT j=4 aborts the run.
        set_coef(1, 2, 3, 4);
        set_samp(7, 7, 7, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("rst_mid_in_shift", 32'(enable), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_load", 32'(load), 0);
        check("rst_mid_enable", 32'(enable), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_y_valid", 32'(y_valid), 0);
        check("rst_mid_y", $signed(y), 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rst_mid_no_valid", 32'(y_valid), 0);
        end
        set_coef(-3, 2, 0, 0);      set_samp(4, 4, 0, 0);           run("after_rst", -4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
